tof_frame_scheduler: RTL
========================

# tof_frame_scheduler

Sequences and arbitrates the single read port B of the ToF frame BRAM (8 sensors × 64 zones = 512 × 16-bit entries) once the write FSM reports a complete frame. Per frame it streams all 512 addresses to the sphere-surface unit, then to the plane-surface unit, and qualifies `doutb` for each consumer with enable and last strobes. Between frames it grants single-word reads to a host requester. It counts frames dropped while busy.

## Interface
Parameters:
- `ADDR_W`, 9: BRAM port-B address width.
- `DEPTH`, 512: entries per frame. Must equal 2^`ADDR_W`.
- `RD_LAT`, 1: BRAM read latency in cycles. Legal range 1..3.

Ports:
- `clk`  in  1  single system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `frame_rdy`  in  1  one-cycle pulse: frame fully written to BRAM.
- `host_req`  in  1  host read request; held until granted.
- `host_addr`  in  `ADDR_W`  host read address, valid while `host_req`.
- `host_gnt`  out  1  combinational; transfer occurs when `host_req` & `host_gnt`.
- `host_vld`  out  1  `doutb` holds host data.
- `bram_addrb`  out  `ADDR_W`  registered BRAM port-B address.
- `sph_en`  out  1  `doutb` valid for the sphere unit.
- `sph_last`  out  1  with the final `sph_en`.
- `plane_en`  out  1  `doutb` valid for the plane unit.
- `plane_last`  out  1  with the final `plane_en`.
- `busy`  out  1  frame pass in progress.
- `frame_done`  out  1  one-cycle pulse: both passes complete.
- `overrun_cnt`  out  8  saturating count of dropped frames.

## Operation
- States:
  - IDLE → SPH on `frame_rdy`.
  - SPH → PLN after address `DEPTH-1`.
  - PLN → DRAIN after address `DEPTH-1`.
  - DRAIN → IDLE after `RD_LAT` cycles.
- One 9-bit address counter is shared by SPH and PLN. It starts at 0, increments by 1 per cycle with no stalls, and wraps 511→0 on the SPH→PLN hand-off.
- `sph_en`/`plane_en`/`sph_last`/`plane_last` are address-phase tags delayed by `RD_LAT` cycles, so each strobe aligns with its `doutb` word.
- `busy` = (state != IDLE).
- `frame_done` asserts in the first IDLE cycle after DRAIN.
- Host arbitration:
  - `host_gnt` = IDLE & `host_req` & !`frame_rdy`. A frame takes priority over a host read in the same cycle.
  - On a grant, `bram_addrb` <= `host_addr` in the next cycle. `host_vld` follows `RD_LAT` cycles after that.
  - Back-to-back host grants are allowed every IDLE cycle.
  - A host read in flight when a frame starts still produces its `host_vld`, because the tag pipelines are independent.
- Overrun: `frame_rdy` while `busy` is ignored and `overrun_cnt` increments, saturating at 255.
- `frame_rdy` in the `frame_done` cycle is accepted normally.
- When nothing is issued in IDLE, `bram_addrb` holds its last value.
- Reset: every register and output goes to 0 immediately, including `overrun_cnt`. State goes to IDLE and the tag pipelines are flushed. `host_gnt` is forced to 0 while `rst_n` is low. No stale `en`/`last`/`vld`/`done` may appear after release.

## Timing
- `frame_rdy` sampled high in cycle 0 (IDLE):
  - `bram_addrb` = 0..511 in cycles 1..512 (SPH), then 0..511 in cycles 513..1024 (PLN).
  - `sph_en` high in cycles 1+`RD_LAT`..512+`RD_LAT`; `sph_last` in cycle 512+`RD_LAT`.
  - `plane_en` high in cycles 513+`RD_LAT`..1024+`RD_LAT`; `plane_last` in cycle 1024+`RD_LAT`.
  - `busy` high in cycles 1..1024+`RD_LAT`.
  - `frame_done` pulses in cycle 1025+`RD_LAT`, the first IDLE cycle.
- Host latency: grant cycle g → address presented in g+1 → `host_vld` in g+1+`RD_LAT`.

## Configuration
- `TOF_SCHED_PLANE_PASS_EN` defined: behaviour as above.
- Undefined:
  - PLN state is removed; SPH → DRAIN.
  - `plane_en`/`plane_last` are tied to 0.
  - `busy` is high in cycles 1..512+`RD_LAT`; `frame_done` pulses in cycle 513+`RD_LAT`.

## Structure
- Package `tof_sched_pkg`: state enum `sched_state_t`, `FRAME_DEPTH`=512, `ZONES_PER_SENSOR`=64, `NUM_SENSORS`=8.
- Sub-module `tof_sched_tag_pipe`: `RD_LAT`-deep shift register carrying {sph_en, sph_last, plane_en, plane_last, host_vld}, with async active-low clear.

## Test plan
- `RD_LAT`=1, single `frame_rdy` → addresses 0..511 twice; 512 `sph_en` (`sph_last` at cycle 513), 512 `plane_en` (`plane_last` at cycle 1025); `frame_done` at cycle 1026.
- `frame_rdy` pulses at cycles 100 and 700 of a pass → both ignored; `overrun_cnt`=2; exactly one `frame_done`.
- `host_req` with `host_addr`=0x1A5 in IDLE and `RD_LAT`=2 → `host_gnt` in cycle g, `bram_addrb`=0x1A5 in g+1, `host_vld` in g+3. Same request with `frame_rdy` in the same cycle → `host_gnt`=0; SPH starts.
- `rst_n` low at cycle 300 of SPH → all outputs 0 at once; after release, no strobes until the next `frame_rdy`; a new frame then runs normally from address 0.
- 260 overrun pulses → `overrun_cnt` saturates at 255.
- Macro undefined, `RD_LAT`=3 → 512 `sph_en` only; `plane_en` never asserts; `frame_done` at cycle 516.

Source files
------------

// File: rtl/tof_sched_pkg.sv
// Shared types and constants for the ToF frame scheduler.
// PLN exists only when TOF_SCHED_PLANE_PASS_EN is defined.
package tof_sched_pkg;

  localparam int unsigned NUM_SENSORS      = 8;
  localparam int unsigned ZONES_PER_SENSOR = 64;
  localparam int unsigned FRAME_DEPTH      = NUM_SENSORS * ZONES_PER_SENSOR;

  // Bit positions inside the read-latency tag word.
  localparam int unsigned TAG_W        = 5;
  localparam int unsigned TAG_SPH      = 4;
  localparam int unsigned TAG_SPH_LAST = 3;
  localparam int unsigned TAG_PLN      = 2;
  localparam int unsigned TAG_PLN_LAST = 1;
  localparam int unsigned TAG_HOST     = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SPH   = 2'd1,
`ifdef TOF_SCHED_PLANE_PASS_EN
    PLN   = 2'd2,
`endif
    DRAIN = 2'd3
  } sched_state_t;

endpackage

// File: rtl/tof_frame_scheduler_if.sv
// Host single-word read handshake on BRAM port B.
interface tof_frame_scheduler_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              host_req;
  logic [ADDR_W-1:0] host_addr;
  logic              host_gnt;
  logic              host_vld;

  modport master (output host_req, output host_addr, input host_gnt, input host_vld);
  modport slave  (input host_req, input host_addr, output host_gnt, output host_vld);
endinterface

// File: rtl/tof_sched_tag_pipe.sv
// RD_LAT-deep shift register aligning address-phase tags with BRAM doutb.
module tof_sched_tag_pipe #(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned W      = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] tag_d,
  output logic [W-1:0] tag_q
);

  logic [W-1:0] sr [RD_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) sr[i] <= '0;
    end else begin
      sr[0] <= tag_d;
      for (int unsigned i = 1; i < RD_LAT; i++) sr[i] <= sr[i-1];
    end
  end

  assign tag_q = sr[RD_LAT-1];

endmodule

// File: rtl/tof_frame_scheduler.sv
// Port-B sequencer for the ToF frame BRAM: sphere pass, optional plane pass
// (TOF_SCHED_PLANE_PASS_EN), host reads between frames, overrun counting.
module tof_frame_scheduler
  import tof_sched_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DEPTH  = 512,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_rdy,
  tof_frame_scheduler_if.slave  host,
  output logic [ADDR_W-1:0]     bram_addrb,
  output logic                  sph_en,
  output logic                  sph_last,
  output logic                  plane_en,
  output logic                  plane_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic [7:0]            overrun_cnt
);

  sched_state_t     state;
  logic [1:0]       drain_cnt;
  logic             host_tag;
  logic             addr_last;
  logic             in_sph;
  logic             in_pln;
  logic [TAG_W-1:0] tag_d;
  logic [TAG_W-1:0] tag_q;

  assign addr_last     = (bram_addrb == ADDR_W'(DEPTH - 1));
  assign busy          = (state != IDLE);
  assign host.host_gnt = rst_n && (state == IDLE) && host.host_req && !frame_rdy;
  assign in_sph        = (state == SPH);
`ifdef TOF_SCHED_PLANE_PASS_EN
  assign in_pln        = (state == PLN);
`else
  assign in_pln        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bram_addrb  <= '0;
      drain_cnt   <= '0;
      host_tag    <= 1'b0;
      frame_done  <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      host_tag   <= 1'b0;
      frame_done <= 1'b0;
      if (frame_rdy && busy && (overrun_cnt != '1))
        overrun_cnt <= overrun_cnt + 8'd1;

      unique case (state)
        IDLE: begin
          if (frame_rdy) begin
            state      <= SPH;
            bram_addrb <= '0;
          end else if (host.host_gnt) begin
            bram_addrb <= host.host_addr;
            host_tag   <= 1'b1;
          end
        end
        SPH: begin
          // Counter wraps DEPTH-1 -> 0 naturally since DEPTH == 2**ADDR_W.
          bram_addrb <= bram_addrb + ADDR_W'(1);
`ifdef TOF_SCHED_PLANE_PASS_EN
          if (addr_last) state <= PLN;
`else
          if (addr_last) state <= DRAIN;
`endif
        end
`ifdef TOF_SCHED_PLANE_PASS_EN
        PLN: begin
          bram_addrb <= bram_addrb + ADDR_W'(1);
          if (addr_last) state <= DRAIN;
        end
`endif
        DRAIN: begin
          if (drain_cnt == 2'(RD_LAT - 1)) begin
            state      <= IDLE;
            drain_cnt  <= '0;
            frame_done <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags describe the address presented this cycle; the pipe delays them to doutb.
  always_comb begin
    tag_d               = '0;
    tag_d[TAG_SPH]      = in_sph;
    tag_d[TAG_SPH_LAST] = in_sph && addr_last;
    tag_d[TAG_PLN]      = in_pln;
    tag_d[TAG_PLN_LAST] = in_pln && addr_last;
    tag_d[TAG_HOST]     = host_tag;
  end

  tof_sched_tag_pipe #(
    .RD_LAT (RD_LAT),
    .W      (TAG_W)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .tag_d (tag_d),
    .tag_q (tag_q)
  );

  assign sph_en        = tag_q[TAG_SPH];
  assign sph_last      = tag_q[TAG_SPH_LAST];
  assign host.host_vld = tag_q[TAG_HOST];
`ifdef TOF_SCHED_PLANE_PASS_EN
  assign plane_en      = tag_q[TAG_PLN];
  assign plane_last    = tag_q[TAG_PLN_LAST];
`else
  logic unused_pln_tags;
  assign unused_pln_tags = tag_q[TAG_PLN] ^ tag_q[TAG_PLN_LAST];
  assign plane_en        = 1'b0;
  assign plane_last      = 1'b0;
`endif

endmodule
